// File: rtl/pla_pkg.sv
// -----------------------------------------------------------------------------
// pla_pkg
// Shared types and helpers for the runtime-programmable PLA evaluator.
//   - PLA_NUM_* : default geometry, matching pla_prog_eval's parameter defaults
//   - PLA_MAX_IN: widest input vector term_match() handles
//   - pla_row_t : one AND/OR-plane row (enable, care mask, value mask, OR mask)
//   - term_match: product-term compare of an input vector against one row
// -----------------------------------------------------------------------------
package pla_pkg;

  localparam int PLA_NUM_IN    = 6;
  localparam int PLA_NUM_OUT   = 12;
  localparam int PLA_NUM_TERMS = 32;
  localparam int PLA_MAX_IN    = 32;

  typedef struct packed {
    logic                   en;
    logic [PLA_NUM_IN-1:0]  care;
    logic [PLA_NUM_IN-1:0]  val;
    logic [PLA_NUM_OUT-1:0] or_mask;
  } pla_row_t;

  // Callers zero-extend to PLA_MAX_IN; the zero-extended care bits keep the
  // unused upper positions out of the compare.
  function automatic logic term_match(input logic [PLA_MAX_IN-1:0] x,
                                      input logic [PLA_MAX_IN-1:0] care,
                                      input logic [PLA_MAX_IN-1:0] val);
    return ((x ^ val) & care) == '0;
  endfunction

endpackage

// File: rtl/pla_prog_eval_term_row.sv
// -----------------------------------------------------------------------------
// pla_term_row
// One product-term row: its enable/care/value/OR registers plus the match
// logic evaluated against the live input vector.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   we            overwrite this row with the cfg_* fields on the next edge
//   cfg_en/care/val/or_mask  new row contents
//   x             input vector to evaluate
//   term          1 when the row is enabled and x matches it
//   or_mask       this row's OR-plane mask
// -----------------------------------------------------------------------------
module pla_term_row
  import pla_pkg::*;
#(
  parameter int NUM_IN  = PLA_NUM_IN,
  parameter int NUM_OUT = PLA_NUM_OUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic               cfg_en,
  input  logic [NUM_IN-1:0]  cfg_care,
  input  logic [NUM_IN-1:0]  cfg_val,
  input  logic [NUM_OUT-1:0] cfg_or,
  input  logic [NUM_IN-1:0]  x,
  output logic               term,
  output logic [NUM_OUT-1:0] or_mask
);

  logic               en_q,   en_d;
  logic [NUM_IN-1:0]  care_q, care_d;
  logic [NUM_IN-1:0]  val_q,  val_d;
  logic [NUM_OUT-1:0] or_q,   or_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    en_d   = en_q;
    care_d = care_q;
    val_d  = val_q;
    or_d   = or_q;
    if (we) begin
      en_d   = cfg_en;
      care_d = cfg_care;
      val_d  = cfg_val;
      or_d   = cfg_or;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the term table is reset like any other state: an unloaded PLA
    // must evaluate to all zeros, so rows cannot be left as bare storage.
    if (rst) begin
      en_q   <= 1'b0;
      care_q <= '0;
      val_q  <= '0;
      or_q   <= '0;
    end else begin
      en_q   <= en_d;
      care_q <= care_d;
      val_q  <= val_d;
      or_q   <= or_d;
    end
  end

  assign term    = en_q & term_match(PLA_MAX_IN'(x), PLA_MAX_IN'(care_q),
                                     PLA_MAX_IN'(val_q));
  assign or_mask = or_q;

endmodule

// File: rtl/pla_prog_eval.sv
// -----------------------------------------------------------------------------
// pla_prog_eval
// Runtime-programmable, 2-stage pipelined PLA evaluator. The AND plane and OR
// plane live in NUM_TERMS pla_term_row instances loaded over a config
// handshake; input vectors stream through a valid/ready pipeline
// (stage 1 = term vector, stage 2 = z).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_valid/cfg_ready           config write handshake (only when pipe empty)
//   cfg_addr/en/care/val/or       row address and new row contents
//   in_valid/in_ready, x          input vector stream
//   out_valid/out_ready, z        result stream
// Optional (macro PLA_OUT_PHASE_EN):
//   cfg_phase_we, cfg_phase       write the output-phase register instead of a
//                                 row; z becomes OR-plane ^ phase
// -----------------------------------------------------------------------------
module pla_prog_eval
  import pla_pkg::*;
#(
  parameter int NUM_IN    = PLA_NUM_IN,
  parameter int NUM_OUT   = PLA_NUM_OUT,
  parameter int NUM_TERMS = PLA_NUM_TERMS,
  parameter int TERM_AW   = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [TERM_AW-1:0] cfg_addr,
  input  logic               cfg_en,
  input  logic [NUM_IN-1:0]  cfg_care,
  input  logic [NUM_IN-1:0]  cfg_val,
  input  logic [NUM_OUT-1:0] cfg_or,
`ifdef PLA_OUT_PHASE_EN
  input  logic               cfg_phase_we,
  input  logic [NUM_OUT-1:0] cfg_phase,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_IN-1:0]  x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] z
);

  logic                 cfg_fire;
  logic                 row_wr;
  logic                 in_fire;
  logic                 s1_load;
  logic                 s2_load;
  logic [NUM_TERMS-1:0] term_vec;
  logic [NUM_OUT-1:0]   or_arr [NUM_TERMS];
  logic [NUM_OUT-1:0]   z_or;
  logic [NUM_OUT-1:0]   phase;

  logic                 s1_valid_q, s1_valid_d;
  logic [NUM_TERMS-1:0] terms_q,    terms_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [NUM_OUT-1:0]   z_q,        z_d;

  // Config only lands on an empty pipe, so no vector ever sees a half-written
  // table; the two stage valids are the whole emptiness test.
  assign cfg_ready = !s1_valid_q && !s2_valid_q;
  assign cfg_fire  = cfg_valid && cfg_ready;

  assign s2_load   = !s2_valid_q || out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  // A pending config request blocks new inputs so the pipe drains.
  assign in_ready  = s1_load && !cfg_valid;
  assign in_fire   = in_valid && in_ready;

`ifdef PLA_OUT_PHASE_EN
  logic [NUM_OUT-1:0] phase_q, phase_d;

  assign row_wr = cfg_fire && !cfg_phase_we;
  assign phase  = phase_q;

  always_comb begin
    phase_d = phase_q;
    if (cfg_fire && cfg_phase_we) phase_d = cfg_phase;
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end
`else
  assign row_wr = cfg_fire;
  assign phase  = '0;
`endif

  // Out-of-range addresses match no row: the write is accepted and dropped.
  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_row
    pla_term_row #(
      .NUM_IN (NUM_IN),
      .NUM_OUT(NUM_OUT)
    ) u_row (
      .clk     (clk),
      .rst     (rst),
      .we      (row_wr && (cfg_addr == TERM_AW'(t))),
      .cfg_en  (cfg_en),
      .cfg_care(cfg_care),
      .cfg_val (cfg_val),
      .cfg_or  (cfg_or),
      .x       (x),
      .term    (term_vec[t]),
      .or_mask (or_arr[t])
    );
  end

  // OR plane over the registered stage-1 term vector.
  always_comb begin
    z_or = '0;
    for (int t = 0; t < NUM_TERMS; t++) begin
      if (terms_q[t]) z_or = z_or | or_arr[t];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    terms_d    = terms_q;
    s2_valid_d = s2_valid_q;
    z_d        = z_q;
    if (s1_load) begin
      s1_valid_d = in_fire;
      if (in_fire) terms_d = term_vec;
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) z_d = z_or ^ phase;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    if (rst) begin
      s1_valid_q <= 1'b0;
      terms_q    <= '0;
      s2_valid_q <= 1'b0;
      z_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      terms_q    <= terms_d;
      s2_valid_q <= s2_valid_d;
      z_q        <= z_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign z         = z_q;

endmodule

// File: tb/tb_pla_prog_eval.sv
// -----------------------------------------------------------------------------
// tb_pla_prog_eval
// Self-checking bench for pla_prog_eval (NUM_TERMS=24 so an out-of-range row
// address is expressible in cfg_addr). Build with PLA_OUT_PHASE_EN defined to
// also cover the output-phase register.
// -----------------------------------------------------------------------------
module tb_pla_prog_eval;
  import pla_pkg::*;

  localparam int NI = 6;
  localparam int NO = 12;
  localparam int NT = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic          cfg_en;
  logic [NI-1:0] cfg_care;
  logic [NI-1:0] cfg_val;
  logic [NO-1:0] cfg_or;
  logic          cfg_phase_we;
  logic [NO-1:0] cfg_phase;
  logic          in_valid;
  logic          in_ready;
  logic [NI-1:0] x;
  logic          out_valid;
  logic          out_ready;
  logic [NO-1:0] z;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pla_prog_eval #(
    .NUM_IN   (NI),
    .NUM_OUT  (NO),
    .NUM_TERMS(NT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_en      (cfg_en),
    .cfg_care    (cfg_care),
    .cfg_val     (cfg_val),
    .cfg_or      (cfg_or),
`ifdef PLA_OUT_PHASE_EN
    .cfg_phase_we(cfg_phase_we),
    .cfg_phase   (cfg_phase),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .z           (z)
  );

  typedef struct {
    logic [NI-1:0] x;
    logic [NO-1:0] z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Leaves time one unit after the rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row(input logic [AW-1:0] addr, input pla_row_t r);
    cfg_addr = addr;
    cfg_en   = r.en;
    cfg_care = r.care;
    cfg_val  = r.val;
    cfg_or   = r.or_mask;
  endtask

  task automatic cfg_write(input logic [AW-1:0] addr, input pla_row_t r);
    int budget = 0;
    set_row(addr, r);
    cfg_valid = 1'b1;
    #1;
    while (!cfg_ready && budget < 20) begin
      tick();
      #1;
      budget++;
    end
    if (!cfg_ready) check("cfg_ready_timeout", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic eval_one(input string name, input logic [NI-1:0] xv,
                          input logic [NO-1:0] exp);
    int budget = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = xv;
    #1;
    while (!in_ready && budget < 20) begin
      tick();
      #1;
      budget++;
    end
    check({name, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    budget   = 0;
    #1;
    while (!out_valid && budget < 20) begin
      tick();
      #1;
      budget++;
    end
    check({name, "_out_valid"}, out_valid, 1);
    check(name, z, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[6];
    logic [NI-1:0] xs[3];
    logic [NO-1:0] zs[3];
    logic [NO-1:0] outs[4];
    int            idx;
    int            got;
    int            drained;
    int            done;
    int            bad_in_ready;
    int            bad_out;

    vecs[0] = '{x: 6'h00, z: 12'h007};
    vecs[1] = '{x: 6'h01, z: 12'h000};
    vecs[2] = '{x: 6'h3E, z: 12'h007};
    vecs[3] = '{x: 6'h10, z: 12'h807};
    vecs[4] = '{x: 6'h11, z: 12'h800};
    vecs[5] = '{x: 6'h1F, z: 12'h800};

    rst          = 1'b1;
    cfg_valid    = 1'b0;
    cfg_addr     = '0;
    cfg_en       = 1'b0;
    cfg_care     = '0;
    cfg_val      = '0;
    cfg_or       = '0;
    cfg_phase_we = 1'b0;
    cfg_phase    = '0;
    in_valid     = 1'b0;
    x            = '0;
    out_ready    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_in_ready", in_ready, 1);

    // Empty table, exact 2-cycle latency.
    tick();
    in_valid = 1'b1;
    x        = 6'h00;
    #1;
    check("lat_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check("lat_cycle1_out_valid", out_valid, 0);
    tick();
    #1;
    check("lat_cycle2_out_valid", out_valid, 1);
    check("lat_cycle2_z", z, 12'h000);
    tick();

`ifdef PLA_OUT_PHASE_EN
    cfg_phase_we = 1'b1;
    cfg_phase    = 12'h001;
    cfg_write('0, '0);
    cfg_phase_we = 1'b0;
    eval_one("phase_x15", 6'h15, 12'h001);
    cfg_phase_we = 1'b1;
    cfg_phase    = 12'h000;
    cfg_write('0, '0);
    cfg_phase_we = 1'b0;
`endif

    // Row 0: ~x0 -> 007. Row 5: x[5:4]==01 -> 800. Row 7 disabled, row 9 a
    // tautology that drives nothing: neither may affect z.
    cfg_write(5'd0, '{en: 1'b1, care: 6'h01, val: 6'h00, or_mask: 12'h007});
    cfg_write(5'd5, '{en: 1'b1, care: 6'h30, val: 6'h10, or_mask: 12'h800});
    cfg_write(5'd7, '{en: 1'b0, care: 6'h00, val: 6'h00, or_mask: 12'hFFF});
    cfg_write(5'd9, '{en: 1'b1, care: 6'h00, val: 6'h00, or_mask: 12'h000});

    // Streamed table: one vector per cycle, each result two cycles later.
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 6);
      x        = (c < 6) ? vecs[c].x : 6'h00;
      #1;
      if (c < 6) check($sformatf("stream_in_ready_%0d", c), in_ready, 1);
      if (c >= 2) begin
        check($sformatf("stream_out_valid_%0d", c - 2), out_valid, 1);
        check($sformatf("stream_z_%0d", c - 2), z, vecs[c - 2].z);
      end else begin
        check($sformatf("stream_fill_%0d", c), out_valid, 0);
      end
      tick();
    end
    in_valid = 1'b0;

    // Backpressure: three vectors offered with out_ready low.
    xs[0] = 6'h00; zs[0] = 12'h007;
    xs[1] = 6'h01; zs[1] = 12'h000;
    xs[2] = 6'h10; zs[2] = 12'h807;
    idx       = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3);
      x        = (idx < 3) ? xs[idx] : 6'h00;
      #1;
      if (c >= 2) check($sformatf("bp_hold_z_%0d", c), z, 12'h007);
      if (in_valid && in_ready) idx++;
      tick();
    end
    #1;
    check("bp_accepted", idx, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    tick();
    out_ready = 1'b1;
    got       = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      in_valid = (idx < 3);
      x        = (idx < 3) ? xs[idx] : 6'h00;
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        outs[got] = z;
        got++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("bp_drain_count", got, 3);
    check("bp_total_accepted", idx, 3);
    for (int i = 0; i < 3; i++) check($sformatf("bp_order_%0d", i), outs[i], zs[i]);

    // Config request with two vectors in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x         = 6'h00;
    tick();
    x = 6'h11;
    tick();
    x = 6'h3E;
    set_row(5'd2, '{en: 1'b1, care: 6'h00, val: 6'h00, or_mask: 12'h040});
    cfg_valid = 1'b1;
    #1;
    check("cfgflight_cfg_ready_a", cfg_ready, 0);
    check("cfgflight_in_ready_a", in_ready, 0);
    tick();
    #1;
    check("cfgflight_cfg_ready_b", cfg_ready, 0);
    check("cfgflight_in_ready_b", in_ready, 0);
    tick();
    out_ready    = 1'b1;
    got          = 0;
    drained      = -1;
    done         = 0;
    bad_in_ready = 0;
    for (int c = 0; c < 10 && done == 0; c++) begin
      #1;
      if (in_ready) bad_in_ready++;
      if (cfg_ready) begin
        done    = 1;
        drained = got;
      end
      if (out_valid && got < 4) begin
        outs[got] = z;
        got++;
      end
      tick();
    end
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    check("cfgflight_write_accepted", done, 1);
    check("cfgflight_drained_before_ready", drained, 2);
    check("cfgflight_in_ready_blocked", bad_in_ready, 0);
    check("cfgflight_out0", outs[0], 12'h007);
    check("cfgflight_out1", outs[1], 12'h800);
    eval_one("taut_x01", 6'h01, 12'h040);

    // Back-to-back writes on consecutive cycles.
    set_row(5'd10, '{en: 1'b1, care: 6'h3F, val: 6'h3F, or_mask: 12'h100});
    cfg_valid = 1'b1;
    #1;
    check("b2b_ready_0", cfg_ready, 1);
    tick();
    set_row(5'd11, '{en: 1'b1, care: 6'h3F, val: 6'h00, or_mask: 12'h200});
    #1;
    check("b2b_ready_1", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
    eval_one("b2b_x3f", 6'h3F, 12'h140);
    eval_one("b2b_x00", 6'h00, 12'h247);

    // Out-of-range row address: accepted, table unchanged.
    cfg_write(5'd24, '{en: 1'b1, care: 6'h00, val: 6'h00, or_mask: 12'hFFF});
    eval_one("badaddr_x01", 6'h01, 12'h040);
    eval_one("badaddr_x00", 6'h00, 12'h247);

    // Reset with one vector in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = 6'h00;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst     = 1'b0;
    bad_out = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid || z != '0) bad_out++;
      tick();
    end
    check("rstflight_no_output", bad_out, 0);
    check("rstflight_cfg_ready", cfg_ready, 1);
    check("rstflight_in_ready", in_ready, 1);
    eval_one("rstflight_table_cleared", 6'h00, 12'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pla_prog_eval.md
Name: pla_prog_eval

Overview:
Runtime-programmable, pipelined PLA evaluator. It is the parametrised successor to the fixed espresso-generated 6-in/12-out PLA blocks. The AND plane (per-term care/value masks) and the OR plane (per-term output masks) are held in registers and loaded through a config handshake. Input vectors stream through a 2-stage valid/ready pipeline, so one generated PLA can be retargeted to any cover without regenerating RTL.

Parameters:
NUM_IN, 6, input vector width (x)
NUM_OUT, 12, output vector width (z)
NUM_TERMS, 32, product-term rows; must be ≥1
TERM_AW, $clog2(NUM_TERMS) (min 1), config row-address width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when cfg_valid&cfg_ready
cfg_addr  in  TERM_AW  term row index
cfg_en  in  1  term enable
cfg_care  in  NUM_IN  1 = input literal participates in term
cfg_val  in  NUM_IN  required literal polarity where care=1
cfg_or  in  NUM_OUT  outputs this term drives
in_valid  in  1  input vector valid
in_ready  out  1  input accepted when in_valid&in_ready
x  in  NUM_IN  input vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
z  out  NUM_OUT  result vector

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset clears all term rows (en=0, care=0, val=0, or=0) and both pipeline stage valids. After reset: out_valid=0, z=0, cfg_ready=1, in_ready=1. Every output evaluates to 0 until terms are loaded.
- Term t is true iff en[t] and ((x ^ val[t]) & care[t]) == 0. An enabled term with care=0 is a tautology.
- z[j] = OR over t of (term[t] & or[t][j]). A term driving no outputs has no effect.
- Stage 1 registers the NUM_TERMS-bit term vector. Stage 2 registers z. Latency is exactly 2 cycles from the accept edge to out_valid with no backpressure. Throughput is one vector per cycle.
- Pipeline advance rules:
  - s2 loads when (!s2_valid | out_ready).
  - s1 loads when (!s1_valid | s2 loads).
  - in_ready = s1 can load & !cfg_valid.
  - Stalled stages hold their data. out_valid/z stay stable while out_valid & !out_ready.
- Config: cfg_ready = !s1_valid & !s2_valid.
  - While cfg_valid is high, new inputs are blocked and the pipeline drains. This guarantees no vector is evaluated against a half-written table.
  - On cfg_valid&cfg_ready, row cfg_addr is overwritten whole on the next edge.
  - cfg_addr ≥ NUM_TERMS: the write is accepted and dropped (no row changes).
  - Back-to-back config writes are allowed one per cycle.
- Simultaneous cfg_valid and in_valid: config wins, in_ready=0.
- rst mid-stream: in-flight vectors are discarded, no out_valid follows, and the table is cleared.
- No FSM beyond the two stage-valid flags. Config has no drain counter; emptiness is decided by the flags alone.

Optional Feature:
PLA_OUT_PHASE_EN:
- Defined: adds a NUM_OUT-bit phase register, reset to 0, plus input port cfg_phase_we (1 bit) and cfg_phase (NUM_OUT bits).
  - The phase write follows the same cfg_ready rule; cfg_phase_we qualifies it in place of a row write in that cycle (cfg_addr ignored).
  - Stage 2 output becomes z = OR-plane ^ phase. This gives espresso-style output phase assignment, e.g. ~x0 covers realised with one term.
- Undefined: no phase port or register; z = OR-plane.

Decomposition:
- Package pla_pkg:
  - pla_row_t struct (en, care, val, or), parametrised by width via localparam defaults matching the module.
  - Function term_match(x, care, val).
- One natural sub-module, pla_term_row: one row's registers plus its match logic, instantiated NUM_TERMS times via generate.
- The OR plane and pipeline stay in the top.

Test Plan:
- Reset, then in_valid x=6'h00 → z=12'h000 at out_valid two cycles later; cfg_ready=1 and in_ready=1 after reset.
- Load row0 en=1, care=6'h01, val=6'h00, or=12'h007; stream x=6'h00, 6'h01, 6'h3E → z=007, 000, 007 on consecutive cycles, latency 2.
- Hold out_ready=0 with 3 vectors offered → exactly 2 accepted, in_ready=0, z held stable; release → remaining vector flows, order preserved.
- Assert cfg_valid while 2 vectors are in flight → cfg_ready=0 until both have drained via out_ready, in_ready=0 throughout; write accepted the cycle after the pipe is empty.
- Write cfg_addr=NUM_TERMS (invalid) with or=all-ones, then evaluate x=6'h00 → z unchanged from the prior table. Also pulse rst with one vector in flight → no out_valid and z=0 afterwards.
- With PLA_OUT_PHASE_EN: phase=12'h001 on an empty table, x=6'h15 → z=12'h001.
